// File: rtl/grid_entry_ctrl.sv
// Keypad entry controller: debounces one-hot keypad codes, edits a 3x3 occupancy
// grid, and hands the grid to an external classifier on '#', presenting its verdict.
module grid_entry_ctrl #(
  parameter int DEB_CYCLES = 8,
  parameter int REL_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] key_code,
  input  logic        key_valid,
  input  logic        mlp_done,
  input  logic [1:0]  mlp_result,
  output logic [8:0]  grid,
  output logic        mlp_start,
  output logic [1:0]  result,
  output logic        result_valid,
  output logic        busy
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(REL_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUBMIT = 2'd1,
    WAIT   = 2'd2,
    SHOW   = 2'd3
  } state_t;

  logic [11:0]   cand_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic [RW-1:0] rel_cnt_reg;
  logic          armed_reg;
  logic          press_reg;
  logic [11:0]   press_code_reg;

  state_t        state_reg;
  logic [8:0]    grid_reg;
  logic          mlp_start_reg;
  logic [1:0]    result_reg;
  logic          result_valid_reg;
  logic          busy_reg;

  logic key_onehot;
  logic same_key;
  logic deb_reach;
  logic rel_reach;

  assign key_onehot = $onehot(key_code);
  assign same_key   = (key_code == cand_reg);
  assign rel_reach  = !key_valid && (rel_cnt_reg == RW'(REL_CYCLES - 1));

  // True on the sample that brings the debounce counter up to DEB_CYCLES.
  always_comb begin
    deb_reach = 1'b0;
    if (key_valid && key_onehot) begin
      if (!same_key)
        deb_reach = (DEB_CYCLES == 1);
      else
        deb_reach = (deb_cnt_reg == DW'(DEB_CYCLES - 1));
    end
  end

  // Debounce and release tracking run regardless of controller state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_reg       <= '0;
      deb_cnt_reg    <= '0;
      rel_cnt_reg    <= '0;
      armed_reg      <= 1'b1;
      press_reg      <= 1'b0;
      press_code_reg <= '0;
    end else begin
      press_reg <= deb_reach && armed_reg;
      if (deb_reach && armed_reg) begin
        armed_reg      <= 1'b0;
        press_code_reg <= key_code;
      end else if (rel_reach) begin
        armed_reg <= 1'b1;
      end

      if (key_valid) begin
        rel_cnt_reg <= '0;
        if (key_onehot) begin
          if (same_key) begin
            if (deb_cnt_reg != DW'(DEB_CYCLES))
              deb_cnt_reg <= deb_cnt_reg + DW'(1);
          end else begin
            cand_reg    <= key_code;
            deb_cnt_reg <= DW'(1);
          end
        end else begin
          cand_reg    <= '0;
          deb_cnt_reg <= '0;
        end
      end else begin
        cand_reg    <= '0;
        deb_cnt_reg <= '0;
        if (rel_cnt_reg != RW'(REL_CYCLES))
          rel_cnt_reg <= rel_cnt_reg + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      grid_reg         <= '0;
      mlp_start_reg    <= 1'b0;
      result_reg       <= 2'b00;
      result_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (press_reg) begin
            if (|press_code_reg[8:0]) begin
              grid_reg <= grid_reg ^ press_code_reg[8:0];
            end else if (press_code_reg[9]) begin
              grid_reg <= '0;
            end else if (press_code_reg[11]) begin
              state_reg     <= SUBMIT;
              mlp_start_reg <= 1'b1;
              busy_reg      <= 1'b1;
            end
          end
        end
        SUBMIT: begin
          mlp_start_reg <= 1'b0;
          state_reg     <= WAIT;
        end
        WAIT: begin
          if (mlp_done) begin
            result_reg       <= mlp_result;
            result_valid_reg <= 1'b1;
            busy_reg         <= 1'b0;
            state_reg        <= SHOW;
          end
        end
        SHOW: begin
          // Any key dismisses the result; the key itself is swallowed.
          if (press_reg) begin
            result_valid_reg <= 1'b0;
            grid_reg         <= '0;
            state_reg        <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign grid         = grid_reg;
  assign mlp_start    = mlp_start_reg;
  assign result       = result_reg;
  assign result_valid = result_valid_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_grid_entry_ctrl.sv
// Bench for grid_entry_ctrl: directed vector table, reset-abort sequence, and
// randomized key episodes checked against an episode-level grid model.
module tb_grid_entry_ctrl;

  localparam int DEB = 8;
  localparam int REL = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] key_code;
  logic        key_valid;
  logic        mlp_done;
  logic [1:0]  mlp_result;
  logic [8:0]  grid;
  logic        mlp_start;
  logic [1:0]  result;
  logic        result_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  grid_entry_ctrl #(.DEB_CYCLES(DEB), .REL_CYCLES(REL)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .mlp_done(mlp_done), .mlp_result(mlp_result), .grid(grid),
    .mlp_start(mlp_start), .result(result), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] code;
    logic        valid;
    int          cyc;
    logic        done;
    logic [1:0]  res;
    logic [8:0]  e_grid;
    logic        e_start;
    logic        e_busy;
    logic        e_rv;
    logic [1:0]  e_result;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [11:0] code, input logic valid, input int cyc,
                     input logic done, input logic [1:0] res, input logic [8:0] eg,
                     input logic es, input logic eb, input logic erv, input logic [1:0] er);
    vec_t v;
    v.code = code; v.valid = valid; v.cyc = cyc; v.done = done; v.res = res;
    v.e_grid = eg; v.e_start = es; v.e_busy = eb; v.e_rv = erv; v.e_result = er;
    vecs.push_back(v);
  endtask

  // A debounced press (held past DEB) followed by a full release that re-arms.
  task automatic add_press(input logic [11:0] code, input logic [8:0] eg,
                           input logic eb, input logic erv, input logic [1:0] er);
    add(code, 1'b1, DEB + 2, 1'b0, 2'b00, eg, 1'b0, eb, erv, er);
    add(12'h000, 1'b0, REL, 1'b0, 2'b00, eg, 1'b0, eb, erv, er);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grid"}, 16'(grid), 16'h0);
    chk({tag, "_start"}, 16'(mlp_start), 16'h0);
    chk({tag, "_result"}, 16'(result), 16'h0);
    chk({tag, "_rv"}, 16'(result_valid), 16'h0);
    chk({tag, "_busy"}, 16'(busy), 16'h0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    run_cycles(1);
    rst = 1'b0;
  endtask

  initial begin
    logic [8:0]  g;
    logic [8:0]  m_grid;
    logic        m_armed;
    logic [11:0] code;
    logic        onehot;
    int          len_on, len_off, a, b;

    rst = 1'b1; key_code = '0; key_valid = 1'b0; mlp_done = 1'b0; mlp_result = 2'b00;
    run_cycles(2);
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Single key: accept once, no auto-repeat, toggle back after re-arm.
    add(12'h010, 1'b1, DEB + 2, 1'b0, 2'b00, 9'h010, 1'b0, 1'b0, 1'b0, 2'b00);
    add(12'h010, 1'b1, 100, 1'b0, 2'b00, 9'h010, 1'b0, 1'b0, 1'b0, 2'b00);
    add(12'h000, 1'b0, REL, 1'b0, 2'b00, 9'h010, 1'b0, 1'b0, 1'b0, 2'b00);
    add_press(12'h010, 9'h000, 1'b0, 1'b0, 2'b00);
    // Bouncing and multi-bit codes never register.
    for (int i = 0; i < 6; i++)
      add((i % 2) ? 12'h002 : 12'h001, 1'b1, 3, 1'b0, 2'b00, 9'h000, 1'b0, 1'b0, 1'b0, 2'b00);
    add(12'h003, 1'b1, 20, 1'b0, 2'b00, 9'h000, 1'b0, 1'b0, 1'b0, 2'b00);
    add(12'h000, 1'b0, REL, 1'b0, 2'b00, 9'h000, 1'b0, 1'b0, 1'b0, 2'b00);
    add(12'h000, 1'b1, 20, 1'b0, 2'b00, 9'h000, 1'b0, 1'b0, 1'b0, 2'b00);
    add(12'h000, 1'b0, REL, 1'b0, 2'b00, 9'h000, 1'b0, 1'b0, 1'b0, 2'b00);
    // Build 0x0FF, '0' is a no-op, '*' clears.
    g = '0;
    for (int k = 0; k < 8; k++) begin
      g[k] = 1'b1;
      add_press(12'(1 << k), g, 1'b0, 1'b0, 2'b00);
    end
    add_press(12'h400, 9'h0FF, 1'b0, 1'b0, 2'b00);
    add_press(12'h200, 9'h000, 1'b0, 1'b0, 2'b00);
    // Build 0x155 and submit.
    g = '0;
    for (int k = 0; k < 9; k += 2) begin
      g[k] = 1'b1;
      add_press(12'(1 << k), g, 1'b0, 1'b0, 2'b00);
    end
    add(12'h800, 1'b1, DEB + 1, 1'b0, 2'b00, 9'h155, 1'b1, 1'b1, 1'b0, 2'b00);
    add(12'h800, 1'b1, 1, 1'b0, 2'b00, 9'h155, 1'b0, 1'b1, 1'b0, 2'b00);
    add(12'h800, 1'b1, 20, 1'b0, 2'b00, 9'h155, 1'b0, 1'b1, 1'b0, 2'b00);
    add(12'h000, 1'b0, REL, 1'b0, 2'b00, 9'h155, 1'b0, 1'b1, 1'b0, 2'b00);
    add_press(12'h010, 9'h155, 1'b1, 1'b0, 2'b00);
    add(12'h000, 1'b0, 1, 1'b1, 2'b10, 9'h155, 1'b0, 1'b0, 1'b1, 2'b10);
    add(12'h000, 1'b0, 2, 1'b1, 2'b01, 9'h155, 1'b0, 1'b0, 1'b1, 2'b10);
    add(12'h000, 1'b0, 2, 1'b0, 2'b00, 9'h155, 1'b0, 1'b0, 1'b1, 2'b10);
    // Dismiss from SHOW with '3': grid cleared, key not applied.
    add_press(12'h004, 9'h000, 1'b0, 1'b0, 2'b10);
    add_press(12'h010, 9'h010, 1'b0, 1'b0, 2'b10);
    add(12'h000, 1'b0, 2, 1'b1, 2'b01, 9'h010, 1'b0, 1'b0, 1'b0, 2'b10);
    add(12'h000, 1'b0, 2, 1'b0, 2'b00, 9'h010, 1'b0, 1'b0, 1'b0, 2'b10);

    foreach (vecs[i]) begin
      key_code = vecs[i].code; key_valid = vecs[i].valid;
      mlp_done = vecs[i].done; mlp_result = vecs[i].res;
      run_cycles(vecs[i].cyc);
      $display("row %0d code=%h valid=%0d cyc=%0d grid=%h start=%0d busy=%0d rv=%0d result=%0d",
               i, vecs[i].code, vecs[i].valid, vecs[i].cyc, grid, mlp_start, busy, result_valid, result);
      chk($sformatf("row%0d_grid", i), 16'(grid), 16'(vecs[i].e_grid));
      chk($sformatf("row%0d_start", i), 16'(mlp_start), 16'(vecs[i].e_start));
      chk($sformatf("row%0d_busy", i), 16'(busy), 16'(vecs[i].e_busy));
      chk($sformatf("row%0d_rv", i), 16'(result_valid), 16'(vecs[i].e_rv));
      chk($sformatf("row%0d_result", i), 16'(result), 16'(vecs[i].e_result));
    end
    mlp_done = 1'b0;

    // Reset while waiting on the classifier, then a stray mlp_done.
    key_code = 12'h800; key_valid = 1'b1;
    run_cycles(DEB + 4);
    chk("abort_busy_before", 16'(busy), 16'h1);
    key_code = '0; key_valid = 1'b0;
    run_cycles(REL);
    pulse_reset();
    mlp_done = 1'b1; mlp_result = 2'b10;
    run_cycles(2);
    mlp_done = 1'b0;
    $display("abort grid=%h busy=%0d rv=%0d result=%0d", grid, busy, result_valid, result);
    chk_reset_outputs("abort");

    // Armed straight after reset; reserved result 11 is latched as-is.
    key_code = 12'h800; key_valid = 1'b1;
    run_cycles(DEB + 4);
    key_code = '0; key_valid = 1'b0;
    run_cycles(REL);
    mlp_done = 1'b1; mlp_result = 2'b11;
    run_cycles(1);
    mlp_done = 1'b0;
    $display("reserved result=%0d rv=%0d", result, result_valid);
    chk("reserved_result", 16'(result), 16'h3);
    chk("reserved_rv", 16'(result_valid), 16'h1);
    chk("reserved_busy", 16'(busy), 16'h0);

    // Random episodes in IDLE: a run of one code, then a quiet period.
    pulse_reset();
    m_grid = '0;
    m_armed = 1'b1;
    for (int ep = 0; ep < 80; ep++) begin
      a = $urandom_range(0, 11);
      if (a < 11) begin
        code = 12'(1 << a);     // keys 1..9, '*', '0'; never '#'
      end else begin
        a = $urandom_range(0, 11);
        b = (a + 1 + $urandom_range(0, 10)) % 12;
        code = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'((1 << a) | (1 << b));
      end
      onehot = $onehot(code);
      len_on  = $urandom_range(1, 12);
      len_off = $urandom_range(3, 22);
      key_code = code; key_valid = 1'b1;
      run_cycles(len_on);
      key_code = '0; key_valid = 1'b0;
      run_cycles(len_off);
      if (onehot && len_on >= DEB && m_armed) begin
        m_armed = 1'b0;
        if (code[9])
          m_grid = '0;
        else if (!code[10])
          m_grid = m_grid ^ code[8:0];
      end
      if (len_off >= REL)
        m_armed = 1'b1;
      $display("ep %0d code=%h on=%0d off=%0d grid=%h model=%h", ep, code, len_on, len_off, grid, m_grid);
      chk($sformatf("ep%0d_grid", ep), 16'(grid), 16'(m_grid));
      chk($sformatf("ep%0d_busy", ep), 16'(busy), 16'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_entry_ctrl.md
GRID_ENTRY_CTRL -- requirements
Module: grid_entry_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 8: consecutive clk samples of an identical valid key required to accept a press.
REQ-002 Parameter REL_CYCLES, default 16: consecutive clk samples of key_valid=0 required to declare a release.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 key_code  input  12  one-hot key from the keypad scanner: bit0..8 = keys 1..9, bit9 = '*', bit10 = '0', bit11 = '#'.
REQ-006 key_valid  input  1  key_code currently holds a detected key.
REQ-007 mlp_done  input  1  one-cycle pulse from the classifier; result is valid in that cycle.
REQ-008 mlp_result  input  2  classifier result: 00 none, 01 O, 10 X, 11 reserved.
REQ-009 grid  output  9  cell occupancy map; bit i = cell for key i+1.
REQ-010 mlp_start  output  1  one-cycle start pulse to the classifier.
REQ-011 result  output  2  latched classifier result.
REQ-012 result_valid  output  1  high while result is being presented.
REQ-013 busy  output  1  high in SUBMIT and WAIT; key input is ignored while high.

Function
REQ-014 Debounce: a candidate register and counter track key_code; counter increments when key_valid=1 and key_code equals the candidate, reloads to 1 with a new candidate on any change; counter saturates at DEB_CYCLES.
REQ-015 A non-one-hot key_code (zero or multiple bits) with key_valid=1 clears the candidate and counter and never produces a press.
REQ-016 Press event: exactly one single-cycle internal event when the counter reaches DEB_CYCLES and the armed flag is set; the armed flag then clears.
REQ-017 The armed flag sets only after REL_CYCLES consecutive key_valid=0 samples; holding a key generates no repeat presses.
REQ-018 States: IDLE, SUBMIT, WAIT, SHOW; the reset state is IDLE.
REQ-019 IDLE, press of key 1..9: grid bit toggles in the cycle after the event.
REQ-020 IDLE, press of '*': grid clears to 0.
REQ-021 IDLE, press of '0': no action.
REQ-022 IDLE, press of '#': transition to SUBMIT; grid is frozen.
REQ-023 SUBMIT: mlp_start=1 for exactly one cycle, then WAIT.
REQ-024 WAIT: on mlp_done=1, latch mlp_result into result and go to SHOW; press events in WAIT are discarded, not queued.
REQ-025 mlp_done outside WAIT is ignored.
REQ-026 SHOW: result_valid=1 and result is held.
REQ-027 SHOW, any press event: clear result_valid and grid, and go to IDLE; the key is consumed and not applied to the grid.
REQ-028 Debounce and release tracking run in all states, so a key held across a state change is never re-accepted.
REQ-029 mlp_result=11 is latched unchanged; interpretation belongs downstream.

Reset
REQ-030 With rst=1 at a rising edge, the next cycle shows: grid=0, mlp_start=0, result=00, result_valid=0, busy=0, state IDLE, candidate=0, counter=0, release counter=0, armed=1.
REQ-031 rst=1 in any state, including WAIT mid-classification, aborts immediately; a later mlp_done in IDLE is ignored.
REQ-032 rst has priority over every other input in the same cycle.

Verification
REQ-033 key_code=0x010, key_valid=1 for DEB_CYCLES cycles -> grid bit4 set once; hold 100 cycles -> no change; release REL_CYCLES, press again -> bit4 clears.
REQ-034 key_code toggles between 0x001 and 0x002 every 3 cycles with DEB_CYCLES=8 -> grid stays 0; key_code=0x003 held -> grid stays 0.
REQ-035 Set grid=0x155, press '#' -> mlp_start pulse exactly 1 cycle and busy=1; press '5' during WAIT -> grid stays 0x155; mlp_done with mlp_result=10 -> result=10, result_valid=1, busy=0.
REQ-036 In SHOW, press '3' -> result_valid=0, grid=0, state IDLE, grid bit2 not set.
REQ-037 Grid 0x0FF, press '*' -> grid=0; press '0' -> no output change.
REQ-038 Assert rst during WAIT, then mlp_done=1 -> all outputs at reset values, no result latched.
